// File: rtl/clas_ctrl_pkg.sv
// Shared constants for the nibble-serial add/sub sequencer.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
// Contents: nibble width, FSM state encoding, counter width helper.
package clas_ctrl_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // Bits needed to hold values 0..n, i.e. clog2(n+1).
  function automatic int cnt_width(input int n);
    int w;
    w = 1;
    while ((1 << w) < (n + 1)) w++;
    return w;
  endfunction

endpackage

// File: rtl/clas_nibble.sv
// 4-bit carry look-ahead adder/subtractor slice with explicit carry-in.
// Latency: purely combinational.
// Backpressure: none.
// Ports: a, b (nibble operands), sub (invert b), c_in -> sum, c_out, c3 (carry into bit 3).
module clas_nibble
  import clas_ctrl_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a,
  input  logic [NIBBLE_W-1:0] b,
  input  logic                sub,
  input  logic                c_in,
  output logic [NIBBLE_W-1:0] sum,
  output logic                c_out,
  output logic                c3
);

  logic [NIBBLE_W-1:0] bx;
  logic [NIBBLE_W-1:0] g;
  logic [NIBBLE_W-1:0] p;
  logic [NIBBLE_W:0]   c;

  always_comb begin
    // Subtraction is a + ~b + 1; the +1 arrives through c_in on the first nibble.
    bx = b ^ {NIBBLE_W{sub}};
    g  = a & bx;
    p  = a ^ bx;

    c[0] = c_in;
    c[1] = g[0] | (p[0] & c_in);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c_in);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c_in);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & c_in);

    sum   = p ^ c[NIBBLE_W-1:0];
    c_out = c[4];
    c3    = c[3];
  end

endmodule

// File: rtl/clas_serial_ctrl.sv
// Multi-precision add/sub run one nibble per clock, LSB first, through one CLA slice.
// Latency: done pulses NIBBLES clocks after start is sampled.
// Backpressure: start is ignored while busy; no queueing.
// Ports: clk, rst_n (sync, active-low), start/op_sub/a/b in; busy, done, result, c_out, ovf, zero out.
module clas_serial_ctrl
  import clas_ctrl_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic                      op_sub,
  input  logic [4*NIBBLES-1:0]      a,
  input  logic [4*NIBBLES-1:0]      b,
  output logic                      busy,
  output logic                      done,
  output logic [4*NIBBLES-1:0]      result,
  output logic                      c_out,
  output logic                      ovf,
  output logic                      zero
);

  localparam int WIDTH = NIBBLE_W * NIBBLES;
  localparam int CNT_W = cnt_width(NIBBLES);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NIBBLES - 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic               sub_q, sub_d;
  logic               carry_q, carry_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               c_out_q, c_out_d;
  logic               ovf_q, ovf_d;
  logic               zero_q, zero_d;
  logic               done_q, done_d;

  logic [NIBBLE_W-1:0] nib_sum;
  logic                nib_cout;
  logic                nib_c3;

  // Operand registers shift right each step so the current nibble is always at [3:0].
  clas_nibble u_nibble (
    .a     (a_q[NIBBLE_W-1:0]),
    .b     (b_q[NIBBLE_W-1:0]),
    .sub   (sub_q),
    .c_in  (carry_q),
    .sum   (nib_sum),
    .c_out (nib_cout),
    .c3    (nib_c3)
  );

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      sub_q    <= 1'b0;
      carry_q  <= 1'b0;
      result_q <= '0;
      c_out_q  <= 1'b0;
      ovf_q    <= 1'b0;
      zero_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_q      <= a_d;
      b_q      <= b_d;
      acc_q    <= acc_d;
      sub_q    <= sub_d;
      carry_q  <= carry_d;
      result_q <= result_d;
      c_out_q  <= c_out_d;
      ovf_q    <= ovf_d;
      zero_q   <= zero_d;
      done_q   <= done_d;
    end
  end

  // Next-state and datapath
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_d      = a_q;
    b_d      = b_q;
    acc_d    = acc_q;
    sub_d    = sub_q;
    carry_d  = carry_q;
    result_d = result_q;
    c_out_d  = c_out_q;
    ovf_d    = ovf_q;
    zero_d   = zero_q;
    done_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          sub_d   = op_sub;
          carry_d = op_sub;
          cnt_d   = '0;
          acc_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        a_d     = a_q >> NIBBLE_W;
        b_d     = b_q >> NIBBLE_W;
        // New nibble enters at the top; after NIBBLES steps it has walked to its place.
        acc_d   = {nib_sum, acc_q[WIDTH-1:NIBBLE_W]};
        carry_d = nib_cout;
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_CNT) begin
          state_d  = ST_IDLE;
          result_d = acc_d;
          c_out_d  = nib_cout;
          // Final nibble holds the MSB, so its bit-3 carry-in is the carry into the MSB.
          ovf_d    = nib_c3 ^ nib_cout;
          zero_d   = (acc_d == '0);
          done_d   = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    busy   = (state_q == ST_RUN);
    done   = done_q;
    result = result_q;
    c_out  = c_out_q;
    ovf    = ovf_q;
    zero   = zero_q;
  end

endmodule

// File: tb/tb_clas_serial_ctrl.sv
// Self-checking bench for clas_serial_ctrl with directed cases and random operations.
// Latency: checks done arrives exactly NIBBLES clocks after start.
// Backpressure: checks starts while busy are dropped and starts in the done cycle are taken.
module tb_clas_serial_ctrl;

  localparam int N = 4;
  localparam int W = 4 * N;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         op_sub = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy, done, c_out, ovf, zero;
  logic [W-1:0] result;

  int n_tests = 0;
  int n_fail  = 0;

  // Last published result, expected to hold steady during later runs.
  logic [W-1:0] held_res = '0;

  clas_serial_ctrl #(.NIBBLES(N)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .op_sub (op_sub),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .result (result),
    .c_out  (c_out),
    .ovf    (ovf),
    .zero   (zero)
  );

  always #5 clk = ~clk;

  task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: signed/unsigned integer arithmetic on whole operands.
  task automatic model(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic ts,
                       output logic [W-1:0] r, output logic c, output logic v, output logic z);
    int sa, sb, sr;
    sa = $signed(ta);
    sb = $signed(tb);
    sr = ts ? (sa - sb) : (sa + sb);
    r  = sr[W-1:0];
    c  = ts ? (ta >= tb) : ((int'(ta) + int'(tb)) >= (1 << W));
    v  = (sr > ((1 << (W - 1)) - 1)) || (sr < -(1 << (W - 1)));
    z  = (r == '0);
  endtask

  // Waits (bounded) for done, checking the held result each cycle; returns cycles waited.
  task automatic wait_done(input string tag, output int cyc);
    cyc = 0;
    while (!done && cyc < 3 * N) begin
      chk_eq({tag, ".hold"}, result, held_res);
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  task automatic check_result(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb,
                              input logic ts, input int cyc);
    logic [W-1:0] er;
    logic ec, ev, ez;
    model(ta, tb, ts, er, ec, ev, ez);
    chk_eq({tag, ".lat"},  cyc, N);
    chk_eq({tag, ".busy_done"}, busy, 1'b0);
    chk_eq({tag, ".res"},  result, er);
    chk_eq({tag, ".cout"}, c_out, ec);
    chk_eq({tag, ".ovf"},  ovf, ev);
    chk_eq({tag, ".zero"}, zero, ez);
    held_res = er;
  endtask

  task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic ts,
                       input string tag);
    int cyc;
    @(negedge clk);
    a = ta; b = tb; op_sub = ts; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    // Scramble inputs after acceptance; they must not matter.
    a = W'($urandom); b = W'($urandom); op_sub = 1'($urandom);
    chk_eq({tag, ".busy"}, busy, 1'b1);
    wait_done(tag, cyc);
    check_result(tag, ta, tb, ts, cyc);
    @(posedge clk); #1;
    chk_eq({tag, ".pulse"}, done, 1'b0);
  endtask

  initial begin
    int cyc;
    int pulses;
    logic [W-1:0] ra, rb;

    repeat (3) @(posedge clk);
    #1;
    chk_eq("rst.busy", busy, 1'b0);
    chk_eq("rst.done", done, 1'b0);
    chk_eq("rst.res",  result, '0);
    chk_eq("rst.cout", c_out, 1'b0);
    chk_eq("rst.ovf",  ovf, 1'b0);
    chk_eq("rst.zero", zero, 1'b0);
    rst_n = 1'b1;

    do_op(16'h1234, 16'h0FFF, 1'b0, "add");
    do_op(16'h0005, 16'h0007, 1'b1, "sub_borrow");
    do_op(16'h8000, 16'h0001, 1'b1, "sub_ovf");
    do_op(16'hFFFF, 16'h0001, 1'b0, "ripple");
    do_op(16'h7FFF, 16'h0001, 1'b0, "add_ovf");
    do_op(16'h1111, 16'h2222, 1'b0, "opchg");
    do_op(16'h0000, 16'h0000, 1'b1, "sub_zero");

    // Start while busy is dropped; start in the done cycle is accepted.
    @(negedge clk);
    a = 16'h0001; b = 16'h0001; op_sub = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    a = 16'hAAAA; b = 16'h5555;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 1;
    while (!done && cyc < 3 * N) begin
      @(posedge clk); #1;
      cyc++;
    end
    check_result("busy_ign", 16'h0001, 16'h0001, 1'b0, cyc);
    a = 16'h0003; b = 16'h0004; op_sub = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk_eq("done_cyc.busy", busy, 1'b1);
    chk_eq("done_cyc.single", done, 1'b0);
    wait_done("done_cyc", cyc);
    check_result("done_cyc", 16'h0003, 16'h0004, 1'b0, cyc);

    // Reset mid-operation.
    @(negedge clk);
    a = 16'h1234; b = 16'h1111; op_sub = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk_eq("mid_rst.busy", busy, 1'b0);
    chk_eq("mid_rst.res",  result, '0);
    chk_eq("mid_rst.cout", c_out, 1'b0);
    chk_eq("mid_rst.ovf",  ovf, 1'b0);
    chk_eq("mid_rst.zero", zero, 1'b0);
    pulses = 0;
    for (int i = 0; i < 2 * N; i++) begin
      if (done) pulses++;
      if (i == 1) rst_n = 1'b1;
      @(posedge clk); #1;
    end
    chk_eq("mid_rst.no_done", pulses, 0);
    held_res = '0;
    do_op(16'h1234, 16'h1111, 1'b0, "post_rst");

    // Random operations with occasional corner operands.
    for (int i = 0; i < 40; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      case ($urandom_range(0, 5))
        0: ra = '1;
        1: rb = '0;
        2: ra = {1'b1, {(W-1){1'b0}}};
        3: rb = ra;
        default: ;
      endcase
      do_op(ra, rb, 1'($urandom), "rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
